// File: rtl/branch_stack_pkg.sv
// Shared definitions for the branch checkpoint stack: reorder-buffer sizing,
// physical-tag / freelist-pointer widths and the checkpoint record layout.
package branch_stack_pkg;

    // Reorder-buffer entry count; also the freelist length.
    localparam int N_ENTRY_ROB = 32;

    // Default number of branch checkpoint slots.
    localparam int N_BR_STACK = 4;

    // Physical-tag width (architectural + ROB-sized rename pool).
    localparam int TW = $clog2(N_ENTRY_ROB + 33);

    // Freelist pointer width.
    localparam int PW = $clog2(N_ENTRY_ROB);

    // Freelist tag snapshot, one tag per freelist entry.
    typedef logic [N_ENTRY_ROB-1:0][TW-1:0] tag_table_t;

    // One checkpoint: everything needed to rewind the freelist.
    typedef struct packed {
        tag_table_t      tag_table;
        logic [PW-1:0]   pointer;
        logic            empty;
    } br_ckpt_t;

endpackage : branch_stack_pkg

// File: rtl/branch_stack.sv
// Branch checkpoint stack. Each dispatched branch saves a freelist snapshot in
// a circular buffer. A mispredicting branch reads its snapshot back in the same
// cycle so the freelist can be restored, and squashes itself plus every younger
// checkpoint. Correctly-predicted branches free their slot, possibly out of
// order; the head retires at most one free slot per cycle.
module branch_stack
    import branch_stack_pkg::*;
#(
    parameter int DEPTH = N_BR_STACK
) (
    input  logic                          clock,
    input  logic                          reset,

    input  logic                          push_br,
    input  tag_table_t                    tag_table_br,
    input  logic [PW-1:0]                 pointer_br,
    input  logic                          empty_br,

    input  logic                          br_resolve,
    input  logic [$clog2(DEPTH)-1:0]      br_resolve_id,
    input  logic                          br_mispred,

    output logic [$clog2(DEPTH)-1:0]      br_id,
    output logic                          full,
    output tag_table_t                    recovery_tag_table,
    output logic [PW-1:0]                 recovery_pointer,
    output logic                          recovery_empty,
    output logic [DEPTH-1:0]              valid_mask
);

    localparam int IW   = $clog2(DEPTH);
    localparam int PW_B = IW + 1;

    // Head (oldest) and tail (next free) carry an extra wrap bit so that
    // full and empty can be told apart when the index bits match.
    logic [PW_B-1:0]  head_q, head_d;
    logic [PW_B-1:0]  tail_q, tail_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    br_ckpt_t         ckpt_q [DEPTH];

    logic [IW-1:0] head_idx;
    logic [IW-1:0] tail_idx;
    logic          empty;
    logic          resolve_hit;
    logic          mispred_fire;
    logic          push_fire;
    br_ckpt_t      snapshot;
    br_ckpt_t      recovery;

    assign head_idx = head_q[IW-1:0];
    assign tail_idx = tail_q[IW-1:0];
    assign empty    = (head_q == tail_q);
    assign full     = (head_idx == tail_idx) && (head_q[IW] != tail_q[IW]);

    // A resolve naming a slot that is already free is a no-op.
    assign resolve_hit  = br_resolve && valid_q[br_resolve_id];
    assign mispred_fire = resolve_hit && br_mispred;

    // Any mispredict in the cycle drops the push: the pushing branch is on
    // the wrong path and must not get a checkpoint.
    assign push_fire = push_br && !full && !(br_resolve && br_mispred);

    assign snapshot = '{tag_table: tag_table_br, pointer: pointer_br, empty: empty_br};

    assign br_id      = tail_idx;
    assign valid_mask = valid_q;

    // Zero-latency read so the freelist restores in the mispredict cycle.
    assign recovery           = ckpt_q[br_resolve_id];
    assign recovery_tag_table = recovery.tag_table;
    assign recovery_pointer   = recovery.pointer;
    assign recovery_empty     = recovery.empty;

    // Slots from id (inclusive) to tail (exclusive), walking in age order
    // starting at head. Offsets are taken relative to head so the compare
    // works across the index wrap.
    function automatic logic [DEPTH-1:0] younger_mask(
        input logic [PW_B-1:0] head,
        input logic [PW_B-1:0] tail,
        input logic [IW-1:0]   id
    );
        logic [DEPTH-1:0] mask;
        logic [PW_B-1:0]  count;
        logic [IW-1:0]    off_id;
        logic [IW-1:0]    off_i;
        mask   = '0;
        count  = tail - head;
        off_id = id - head[IW-1:0];
        for (int i = 0; i < DEPTH; i++) begin
            off_i = IW'(i) - head[IW-1:0];
            if ((off_i >= off_id) && ({1'b0, off_i} < count)) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

    // Next-state for head, tail and the valid bits.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, otherwise
        // a path that skips the assignment infers a latch.
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;

        if (resolve_hit) begin
            valid_d[br_resolve_id] = 1'b0;
        end

        if (mispred_fire) begin
            valid_d = valid_d & ~younger_mask(head_q, tail_q, br_resolve_id);
            // Rebuild tail from head so its wrap bit is consistent.
            tail_d  = head_q + {1'b0, IW'(br_resolve_id - head_idx)};
        end else if (push_fire) begin
            valid_d[tail_idx] = 1'b1;
            tail_d            = tail_q + PW_B'(1);
        end

        // Retire one freed slot per cycle from the oldest end.
        if (!empty && !valid_q[head_idx]) begin
            head_d = head_q + PW_B'(1);
        end
    end

    // Pointer and valid state, cleared asynchronously on reset.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, independent of statement order.
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
        end
    end

    // Snapshot storage; written on every accepted push.
    always_ff @(posedge clock) begin
        // NOTE: storage is deliberately not reset; the valid bits alone say
        // whether a slot means anything, which keeps this plain RAM.
        if (push_fire) begin
            ckpt_q[tail_idx] <= snapshot;
        end
    end

endmodule : branch_stack

// File: tb/tb_branch_stack.sv
// Directed self-checking bench for branch_stack: fill/full, retire, mispredict
// recovery, push/mispredict collision, out-of-order resolves, async reset.
module tb_branch_stack;
    import branch_stack_pkg::*;

    localparam int DEPTH = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             push_br = 1'b0;
    tag_table_t       tag_table_br = '0;
    logic [PW-1:0]    pointer_br = '0;
    logic             empty_br = 1'b0;
    logic             br_resolve = 1'b0;
    logic [1:0]       br_resolve_id = '0;
    logic             br_mispred = 1'b0;
    logic [1:0]       br_id;
    logic             full;
    tag_table_t       recovery_tag_table;
    logic [PW-1:0]    recovery_pointer;
    logic             recovery_empty;
    logic [DEPTH-1:0] valid_mask;

    int total = 0;
    int bad   = 0;

    branch_stack #(.DEPTH(DEPTH)) dut (
        .clock              (clock),
        .reset              (reset),
        .push_br            (push_br),
        .tag_table_br       (tag_table_br),
        .pointer_br         (pointer_br),
        .empty_br           (empty_br),
        .br_resolve         (br_resolve),
        .br_resolve_id      (br_resolve_id),
        .br_mispred         (br_mispred),
        .br_id              (br_id),
        .full               (full),
        .recovery_tag_table (recovery_tag_table),
        .recovery_pointer   (recovery_pointer),
        .recovery_empty     (recovery_empty),
        .valid_mask         (valid_mask)
    );

    always #5 clock = ~clock;

    // Distinct tag pattern per snapshot pointer value.
    function automatic tag_table_t pat(input int p);
        tag_table_t t;
        for (int j = 0; j < N_ENTRY_ROB; j++) begin
            t[j] = TW'((p * 3 + j) % 128);
        end
        return t;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        push_br    = 1'b0;
        br_resolve = 1'b0;
        br_mispred = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        #1;
        chk("rst_full", full, 0);
        chk("rst_br_id", br_id, 0);
        chk("rst_valid", valid_mask, 0);
        tick();
        reset = 1'b0;
    endtask

    // Push one branch with snapshot p and check its allocated id.
    task automatic push(input int p, input logic [1:0] exp_id, input string tag);
        push_br      = 1'b1;
        pointer_br   = PW'(p);
        tag_table_br = pat(p);
        empty_br     = p[0];
        #1;
        chk(tag, br_id, exp_id);
        tick();
        push_br = 1'b0;
    endtask

    task automatic resolve(input logic [1:0] id, input logic mis);
        br_resolve    = 1'b1;
        br_resolve_id = id;
        br_mispred    = mis;
    endtask

    initial begin
        // ---- Fill and full ----
        do_reset();
        for (int i = 0; i < 4; i++) push(i, 2'(i), "fill_id");
        chk("fill_full", full, 1);
        chk("fill_valid", valid_mask, 4'b1111);
        push_br = 1'b1; pointer_br = PW'(7); tag_table_br = pat(7);
        tick();
        idle();
        chk("push_full_valid", valid_mask, 4'b1111);
        chk("push_full_full", full, 1);
        chk("push_full_br_id", br_id, 0);
        br_resolve_id = 2'd2;
        #1;
        chk("read_slot2_ptr", recovery_pointer, 2);

        // ---- Correct resolve of oldest, head retires, wrap push ----
        resolve(2'd0, 1'b0);
        tick();
        idle();
        chk("ret_valid", valid_mask, 4'b1110);
        tick();
        chk("ret_full", full, 0);
        push(9, 2'd0, "wrap_id");
        chk("wrap_valid", valid_mask, 4'b1111);
        chk("wrap_full", full, 1);
        br_resolve_id = 2'd0;
        #1;
        chk("wrap_slot0_ptr", recovery_pointer, 9);

        // ---- Mispredict recovery ----
        do_reset();
        for (int i = 0; i < 4; i++) push(i, 2'(i), "mp_fill_id");
        resolve(2'd1, 1'b1);
        #1;
        chk("mp_rec_ptr", recovery_pointer, 1);
        chk("mp_rec_tags", recovery_tag_table, pat(1));
        chk("mp_rec_empty", recovery_empty, 1);
        tick();
        idle();
        chk("mp_valid", valid_mask, 4'b0001);
        chk("mp_tail", br_id, 1);
        chk("mp_full", full, 0);

        // ---- Mispredict with simultaneous push ----
        push(11, 2'd1, "mp2_fill1");
        push(12, 2'd2, "mp2_fill2");
        push(13, 2'd3, "mp2_fill3");
        chk("mp2_full", full, 1);
        resolve(2'd2, 1'b1);
        push_br = 1'b1; pointer_br = PW'(20); tag_table_br = pat(20);
        tick();
        idle();
        chk("mp2_valid", valid_mask, 4'b0011);
        chk("mp2_tail", br_id, 2);
        push(14, 2'd2, "mp2_repush");
        chk("mp2_repush_valid", valid_mask, 4'b0111);

        // ---- Correct resolve and push in the same cycle ----
        resolve(2'd1, 1'b0);
        push(15, 2'd3, "rp_id");
        idle();
        chk("rp_valid", valid_mask, 4'b1101);
        chk("rp_full", full, 1);

        // ---- Resolve of an already-free slot is a no-op ----
        resolve(2'd1, 1'b1);
        tick();
        idle();
        chk("stale_valid", valid_mask, 4'b1101);
        chk("stale_tail", br_id, 0);
        chk("stale_full", full, 1);

        // ---- Out-of-order correct resolves ----
        do_reset();
        for (int i = 0; i < 4; i++) push(i, 2'(i), "ooo_fill_id");
        resolve(2'd2, 1'b0);
        tick();
        resolve(2'd0, 1'b0);
        tick();
        idle();
        chk("ooo_valid", valid_mask, 4'b1010);
        tick();
        chk("ooo_head1_full", full, 0);
        push(30, 2'd0, "ooo_wrap_id");
        chk("ooo_head_at1", full, 1);
        chk("ooo_valid2", valid_mask, 4'b1011);
        tick();
        tick();
        chk("ooo_head_stuck", full, 1);
        resolve(2'd1, 1'b0);
        tick();
        idle();
        chk("ooo_valid3", valid_mask, 4'b1001);
        tick();
        tick();
        tick();
        push(31, 2'd1, "ooo_push_a");
        chk("ooo_not_full", full, 0);
        push(32, 2'd2, "ooo_push_b");
        chk("ooo_head_at3", full, 1);
        chk("ooo_valid4", valid_mask, 4'b1111);

        // ---- Asynchronous reset between edges ----
        do_reset();
        for (int i = 0; i < 3; i++) push(i, 2'(i), "ar_fill_id");
        chk("ar_valid_before", valid_mask, 4'b0111);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_valid", valid_mask, 0);
        chk("ar_full", full, 0);
        chk("ar_br_id", br_id, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("ar_after_valid", valid_mask, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety bound so the run can never hang.
    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule : tb_branch_stack
